// File: rtl/clkgen_pkg.sv
// ---------------------------------------------------------------------------
// clkgen_pkg
//   Shared definitions for the programmable clock divider.
//   - MIN_DIV      : smallest divisor a channel will ever run with.
//   - ch_action_e  : per-edge action a channel takes at each rising clk edge.
//   - clamp_div()  : maps a requested divisor onto the legal range.
// ---------------------------------------------------------------------------
package clkgen_pkg;

   localparam int unsigned MIN_DIV = 2;

   // What a channel does at the next rising edge.
   //   ActRun          : advance the counter (running, or finishing a period)
   //   ActApplyStopped : stopped with a pending divisor, adopt it now
   //   ActHold         : stopped, nothing to do
   typedef enum logic [1:0] {
      ActRun,
      ActApplyStopped,
      ActHold
   } ch_action_e;

   // Divisors 0 and 1 cannot form a 50 % clock; they are stored as MIN_DIV.
   function automatic int unsigned clamp_div(input int unsigned div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

// File: rtl/prog_clock_divider_if.sv
// ---------------------------------------------------------------------------
// prog_clock_divider_if
//   Control/status bundle for prog_clock_divider.
//   div_val  : per-channel divisor, channel i at [i*CNT_W +: CNT_W]
//   div_load : per-channel one-cycle load strobe
//   ch_en    : per-channel run enable (level)
//   clk_out  : per-channel divided clock
//   tick     : per-channel one-cycle strobe at each clk_out rising edge
//   pending  : per-channel loaded divisor not yet applied
//   master modport drives the controls, slave modport is the divider.
// ---------------------------------------------------------------------------
interface prog_clock_divider_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
);

   logic [NUM_CH*CNT_W-1:0] div_val;
   logic [NUM_CH-1:0]       div_load;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       pending;

   modport master (
      output div_val,
      output div_load,
      output ch_en,
      input  clk_out,
      input  tick,
      input  pending
   );

   modport slave (
      input  div_val,
      input  div_load,
      input  ch_en,
      output clk_out,
      output tick,
      output pending
   );

endinterface

// File: rtl/clk_div_channel.sv
// ---------------------------------------------------------------------------
// clk_div_channel
//   One divider channel: 50 %-duty clock for any integer divisor >= 2, a
//   tick strobe at each output rising edge, and glitch-free reprogramming
//   through a shadow register applied only at period boundaries.
//
//   clk        in   source clock (rising edge; odd-divisor flop on falling)
//   rst        in   asynchronous active-high reset
//   div_val_i  in   new divisor
//   div_load_i in   one-cycle strobe capturing div_val_i into the shadow
//   ch_en_i    in   run enable; dropping it lets the current period finish
//   clk_out_o  out  divided clock
//   tick_o     out  one-cycle strobe coincident with clk_out rising
//   pending_o  out  shadow holds a divisor not yet applied
// ---------------------------------------------------------------------------
module clk_div_channel
   import clkgen_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] div_val_i,
   input  logic             div_load_i,
   input  logic             ch_en_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             pending_o
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(clamp_div(DEF_DIV));

   logic [CNT_W-1:0] d_act_q, d_act_d;
   logic [CNT_W-1:0] d_shd_q, d_shd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_p_q, q_p_d;
   logic             q_n_q;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;

   logic             at_end;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] d_eff;
   logic [CNT_W-1:0] load_val;
   ch_action_e       action;

   assign load_val = CNT_W'(clamp_div(32'(div_val_i)));

   // ------------------------------------------------------------------
   // Action decode
   // ------------------------------------------------------------------
   always_comb begin
      at_end   = (cnt_q == (d_act_q - CntOne));
      cnt_next = at_end ? '0 : (cnt_q + CntOne);
      // A period in progress always runs to completion, even with ch_en low;
      // the stopped state is exactly "at_end with ch_en low".
      if (ch_en_i || !at_end) begin
         action = ActRun;
      end else if (pend_q) begin
         action = ActApplyStopped;
      end else begin
         action = ActHold;
      end
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      d_act_d = d_act_q;
      d_shd_d = d_shd_q;
      cnt_d   = cnt_q;
      q_p_d   = 1'b0;
      pend_d  = pend_q;
      tick_d  = 1'b0;
      d_eff   = d_act_q;

      unique case (action)
         ActRun: begin
            cnt_d = cnt_next;
            if (at_end && pend_q) begin
               d_act_d = d_shd_q;
               pend_d  = 1'b0;
               d_eff   = d_shd_q;
            end
            q_p_d  = (cnt_next < (d_eff >> 1));
            tick_d = at_end;
         end
         ActApplyStopped: begin
            d_act_d = d_shd_q;
            cnt_d   = d_shd_q - CntOne;
            pend_d  = 1'b0;
         end
         default: begin
            // ActHold: counter parked at d_act-1, outputs low.
         end
      endcase

      // A load on the apply edge stays pending for the following boundary.
      if (div_load_i) begin
         d_shd_d = load_val;
         pend_d  = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_act_q <= DefDiv;
         d_shd_q <= DefDiv;
         cnt_q   <= DefDiv - CntOne;
         q_p_q   <= 1'b0;
         pend_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         d_act_q <= d_act_d;
         d_shd_q <= d_shd_d;
         cnt_q   <= cnt_d;
         q_p_q   <= q_p_d;
         pend_q  <= pend_d;
         tick_q  <= tick_d;
      end
   end

   // Half-cycle delayed copy of q_p; OR-ing it in stretches the high time of
   // an odd divisor by half a source period.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         q_n_q <= 1'b0;
      end else begin
         q_n_q <= q_p_q;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      clk_out_o = d_act_q[0] ? (q_p_q | q_n_q) : q_p_q;
      tick_o    = tick_q;
      pending_o = pend_q;
   end

endmodule

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
//   NUM_CH independent programmable clock dividers. Each channel produces a
//   50 %-duty divided clock, a tick strobe and a pending flag.
//
//   clk  in   source clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of prog_clock_divider_if (div_val, div_load, ch_en in;
//        clk_out, tick, pending out)
// ---------------------------------------------------------------------------
module prog_clock_divider
   import clkgen_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned DEF_DIV = 2
) (
   input  logic              clk,
   input  logic              rst,
   prog_clock_divider_if.slave bus
);

   logic [NUM_CH-1:0] clk_out_w;
   logic [NUM_CH-1:0] tick_w;
   logic [NUM_CH-1:0] pending_w;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_channel #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .div_val_i  (bus.div_val[i*CNT_W +: CNT_W]),
         .div_load_i (bus.div_load[i]),
         .ch_en_i    (bus.ch_en[i]),
         .clk_out_o  (clk_out_w[i]),
         .tick_o     (tick_w[i]),
         .pending_o  (pending_w[i])
      );
   end

   assign bus.clk_out = clk_out_w;
   assign bus.tick    = tick_w;
   assign bus.pending = pending_w;

endmodule

// File: tb/tb_prog_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clock_divider
//   Reference model: each channel is a sequence of periods. Within a period
//   of divisor d, clk_out is high for the first d half-cycles of clk and low
//   for the remaining d half-cycles; tick marks the first full cycle.
// ---------------------------------------------------------------------------
module tb_prog_clock_divider;

   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DEF_DIV = 2;

   logic clk;
   logic rst;

   prog_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   prog_clock_divider #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state per channel.
   int unsigned m_dact [NUM_CH];
   int unsigned m_dshd [NUM_CH];
   bit          m_pend [NUM_CH];
   bit          m_act  [NUM_CH];
   int unsigned m_k    [NUM_CH];   // cycle index inside the current period

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_dact[c] = DEF_DIV;
         m_dshd[c] = DEF_DIV;
         m_pend[c] = 1'b0;
         m_act[c]  = 1'b0;
         m_k[c]    = 0;
      end
   endfunction

   // Rising edge: end of a period (or idle) is where divisors change and
   // where a new period may begin.
   function automatic void model_posedge();
      for (int c = 0; c < NUM_CH; c++) begin
         bit          boundary;
         int unsigned v;
         boundary = !m_act[c] || (m_k[c] == m_dact[c] - 1);
         if (boundary) begin
            if (m_pend[c]) begin
               m_dact[c] = m_dshd[c];
               m_pend[c] = 1'b0;
            end
            m_act[c] = bus.ch_en[c];
            m_k[c]   = 0;
         end else begin
            m_k[c]++;
         end
         if (bus.div_load[c]) begin
            v         = 32'(bus.div_val[c*CNT_W +: CNT_W]);
            m_dshd[c] = (v < 2) ? 2 : v;
            m_pend[c] = 1'b1;
         end
      end
   endfunction

   task automatic check_phase(input bit low);
      for (int c = 0; c < NUM_CH; c++) begin
         bit exp_clk;
         exp_clk = m_act[c] && ((2 * m_k[c] + 32'(low)) < m_dact[c]);
         check_eq($sformatf("clk_out[%0d]@%s", c, low ? "lo" : "hi"),
                  32'(bus.clk_out[c]), 32'(exp_clk));
         if (!low) begin
            check_eq($sformatf("tick[%0d]", c), 32'(bus.tick[c]),
                     32'(m_act[c] && (m_k[c] == 0)));
            check_eq($sformatf("pending[%0d]", c), 32'(bus.pending[c]),
                     32'(m_pend[c]));
         end
      end
   endtask

   // One source cycle: model update at the rising edge, sample in both halves.
   task automatic step();
      @(posedge clk);
      model_posedge();
      #2;
      check_phase(1'b0);
      @(negedge clk);
      #2;
      check_phase(1'b1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_ch(input int c, input logic [CNT_W-1:0] v);
      bus.div_val[c*CNT_W +: CNT_W] = v;
      bus.div_load[c] = 1'b1;
      step();
      bus.div_load[c] = 1'b0;
   endtask

   initial begin
      int guard;
      rst          = 1'b1;
      bus.div_val  = '0;
      bus.div_load = '0;
      bus.ch_en    = '0;
      model_reset();

      #2;
      check_eq("reset clk_out", 32'(bus.clk_out), 32'(0));
      check_eq("reset tick", 32'(bus.tick), 32'(0));
      check_eq("reset pending", 32'(bus.pending), 32'(0));

      @(negedge clk);
      #2;
      rst = 1'b0;

      // Default divisor 2 on every channel.
      bus.ch_en = '1;
      run(6);

      // ch0 to 5, ch1 to 4 then 28 mid-run.
      load_ch(0, 16'd5);
      run(12);
      load_ch(1, 16'd4);
      run(10);
      load_ch(1, 16'd28);
      run(40);

      // Clamp: 0 behaves as 2.
      load_ch(2, 16'd0);
      run(8);

      // Back-to-back loads: latest wins.
      bus.div_val[3*CNT_W +: CNT_W] = 16'd7;
      bus.div_load[3] = 1'b1;
      step();
      bus.div_val[3*CNT_W +: CNT_W] = 16'd9;
      step();
      bus.div_load[3] = 1'b0;
      run(30);

      // Divide-by-6, drop enable at cnt=1, then re-enable.
      load_ch(2, 16'd6);
      guard = 0;
      while (!(m_act[2] && m_dact[2] == 6 && m_k[2] == 1) && guard < 40) begin
         step();
         guard++;
      end
      check_eq("wait div6 cnt1", 32'(guard < 40), 32'(1));
      bus.ch_en[2] = 1'b0;
      run(12);
      bus.ch_en[2] = 1'b1;
      run(4);

      // Asynchronous reset while the odd channel is high only through its
      // falling-edge flop (third cycle of a divide-by-5 period).
      guard = 0;
      while (!(m_act[0] && m_dact[0] == 5 && m_k[0] == 2) && guard < 40) begin
         @(posedge clk);
         model_posedge();
         #2;
         if (!(m_act[0] && m_dact[0] == 5 && m_k[0] == 2)) begin
            check_phase(1'b0);
            @(negedge clk);
            #2;
            check_phase(1'b1);
         end
         guard++;
      end
      check_eq("wait odd high", 32'(guard < 40), 32'(1));
      check_eq("pre-rst clk_out0", 32'(bus.clk_out[0]), 32'(1));
      rst = 1'b1;
      #1;
      check_eq("async rst clk_out", 32'(bus.clk_out), 32'(0));
      check_eq("async rst tick", 32'(bus.tick), 32'(0));
      check_eq("async rst pending", 32'(bus.pending), 32'(0));
      model_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      run(8);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            bus.div_load[c] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
               bus.div_val[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 40));
            end else begin
               bus.div_val[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 29) == 0) bus.ch_en[c] = ~bus.ch_en[c];
         end
         step();
      end
      bus.div_load = '0;
      run(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
